// File: rtl/rsa_modexp_seq.sv
// Sequential square-and-multiply modular exponentiation: result = base^exponent mod modulus.
// Two interleaved shift-add modular multipliers give a fixed EXP_BITS*(WIDTH+1) cycle latency.
module rsa_modexp_seq #(
  parameter int unsigned WIDTH    = 25,
  parameter int unsigned EXP_BITS = 25
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [WIDTH-1:0]    base,
  input  logic [EXP_BITS-1:0] exponent,
  input  logic [WIDTH-1:0]    modulus,
  output logic                busy,
  output logic                done,
  output logic [WIDTH-1:0]    result,
  output logic                err
);

  localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned IW = (EXP_BITS > 1) ? $clog2(EXP_BITS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_NEXT,
    S_DONE
  } state_t;

  state_t                state_q;
  logic [WIDTH-1:0]      n_q;
  logic [WIDTH-1:0]      r_q;
  logic [WIDTH-1:0]      b_q;
  logic [EXP_BITS-1:0]   e_q;
  logic [WIDTH-1:0]      p1_q;
  logic [WIDTH-1:0]      p2_q;
  logic [WIDTH-1:0]      p1_d;
  logic [WIDTH-1:0]      p2_d;
  logic [BW-1:0]         bit_q;
  logic [IW-1:0]         iter_q;
  logic                  mul_bit;

  // One MSB-first shift-add step; acc stays < n, so WIDTH+1 bits never overflow.
  function automatic logic [WIDTH-1:0] mod_step(input logic [WIDTH-1:0] acc,
                                                 input logic [WIDTH-1:0] addend,
                                                 input logic [WIDTH-1:0] n,
                                                 input logic             bit_v);
    logic [WIDTH:0] t;
    logic [WIDTH:0] nn;
    nn = {1'b0, n};
    t  = {acc, 1'b0};
    if (t >= nn) t = t - nn;
    if (bit_v) begin
      t = t + {1'b0, addend};
      if (t >= nn) t = t - nn;
    end
    return t[WIDTH-1:0];
  endfunction

  // Both products share the multiplier operand B: P1 = R*B, P2 = B*B.
  always_comb begin
    mul_bit = b_q[bit_q];
    p1_d    = mod_step(p1_q, r_q, n_q, mul_bit);
    p2_d    = mod_step(p2_q, b_q, n_q, mul_bit);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      r_q     <= '0;
      b_q     <= '0;
      e_q     <= '0;
      p1_q    <= '0;
      p2_q    <= '0;
      bit_q   <= '0;
      iter_q  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      err     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            n_q    <= modulus;
            e_q    <= exponent;
            b_q    <= base;
            r_q    <= WIDTH'(1);
            p1_q   <= '0;
            p2_q   <= '0;
            bit_q  <= BW'(WIDTH - 1);
            iter_q <= '0;
            result <= '0;
            err    <= 1'b0;
            if ((modulus < WIDTH'(2)) || (base >= modulus)) begin
              err     <= 1'b1;
              done    <= 1'b1;
              state_q <= S_DONE;
            end else begin
              busy    <= 1'b1;
              state_q <= S_MUL;
            end
          end
        end
        S_MUL: begin
          p1_q <= p1_d;
          p2_q <= p2_d;
          if (bit_q == '0) state_q <= S_NEXT;
          else bit_q <= bit_q - BW'(1);
        end
        S_NEXT: begin
          // Products are always formed; only the R update depends on the exponent bit.
          if (e_q[0]) r_q <= p1_q;
          b_q    <= p2_q;
          e_q    <= e_q >> 1;
          iter_q <= iter_q + IW'(1);
          p1_q   <= '0;
          p2_q   <= '0;
          bit_q  <= BW'(WIDTH - 1);
          if (iter_q == IW'(EXP_BITS - 1)) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            result  <= e_q[0] ? p1_q : r_q;
            state_q <= S_DONE;
          end else begin
            state_q <= S_MUL;
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_modexp_seq.sv
// Directed bench for rsa_modexp_seq: known RSA vectors, operand edges, error path and control.
module tb_rsa_modexp_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [24:0] base;
  logic [24:0] exponent;
  logic [24:0] modulus;
  logic        busy;
  logic        done;
  logic [24:0] result;
  logic        err;

  int total = 0;
  int bad   = 0;

  rsa_modexp_seq #(.WIDTH(25), .EXP_BITS(25)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .base     (base),
    .exponent (exponent),
    .modulus  (modulus),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    total++;
    assert (got === expv) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, got, expv);
    end
  endtask

  // Runs one job; poke_at >= 0 pulses a conflicting start that many cycles into the job.
  task automatic run_job(input string tag, input logic [24:0] b, input logic [24:0] e,
                         input logic [24:0] n, input bit check_res, input logic [24:0] exp_res,
                         input logic exp_err, input int poke_at, output logic [24:0] res);
    int lat;
    @(negedge clk);
    base = b; exponent = e; modulus = n; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; base = 25'h1ABCDE; exponent = 25'h0F0F0F; modulus = 25'd0;
    lat = 0;
    @(negedge clk);
    if (!done) begin
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_clr"}, 32'(result), 32'd0);
    end
    while (!done && lat < 2000) begin
      if (lat == poke_at) begin
        start = 1'b1; base = 25'd3; exponent = 25'd7; modulus = 25'd3233;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_lat"}, 32'(lat), exp_err ? 32'd0 : 32'd650);
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
    if (check_res) chk({tag, "_res"}, 32'(result), 32'(exp_res));
    res = result;
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(done), 32'd0);
    chk({tag, "_hold"}, 32'(result), 32'(res));
  endtask

  initial begin
    logic [24:0] r;
    logic [24:0] c;
    rst_n = 1'b0; start = 1'b0; base = '0; exponent = '0; modulus = '0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_res", 32'(result), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    run_job("enc21", 25'd2, 25'd5, 25'd21, 1'b1, 25'd11, 1'b0, -1, r);
    run_job("dec21", 25'd11, 25'd5, 25'd21, 1'b1, 25'd2, 1'b0, -1, r);

    for (int b = 1; b <= 20; b++) begin
      run_job("sw_enc", 25'(b), 25'd5, 25'd21, 1'b0, 25'd0, 1'b0, -1, c);
      run_job("sw_dec", c, 25'd5, 25'd21, 1'b1, 25'(b), 1'b0, -1, r);
    end

    run_job("rsa_enc", 25'd65, 25'd17, 25'd3233, 1'b1, 25'd2790, 1'b0, -1, r);
    run_job("rsa_dec", 25'd2790, 25'd2753, 25'd3233, 1'b1, 25'd65, 1'b0, -1, r);

    run_job("exp0", 25'd5, 25'd0, 25'd21, 1'b1, 25'd1, 1'b0, -1, r);
    run_job("base0", 25'd0, 25'd7, 25'd21, 1'b1, 25'd0, 1'b0, -1, r);
    run_job("nm1sq", 25'd20, 25'd2, 25'd21, 1'b1, 25'd1, 1'b0, -1, r);

    run_job("err_n1", 25'd0, 25'd3, 25'd1, 1'b1, 25'd0, 1'b1, -1, r);
    run_job("err_n0", 25'd0, 25'd3, 25'd0, 1'b1, 25'd0, 1'b1, -1, r);
    run_job("err_bge", 25'd21, 25'd3, 25'd21, 1'b1, 25'd0, 1'b1, -1, r);
    run_job("after_err", 25'd2, 25'd5, 25'd21, 1'b1, 25'd11, 1'b0, -1, r);

    run_job("poke", 25'd2, 25'd5, 25'd21, 1'b1, 25'd11, 1'b0, 100, r);

    // Abort a job mid-flight with reset.
    @(negedge clk);
    base = 25'd65; exponent = 25'd17; modulus = 25'd3233; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (300) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_res", 32'(result), 32'd0);
    chk("abort_err", 32'(err), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (700) begin
      @(negedge clk);
      if (done) break;
    end
    chk("abort_nodone", 32'(done), 32'd0);
    run_job("post_abort", 25'd65, 25'd17, 25'd3233, 1'b1, 25'd2790, 1'b0, -1, r);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
